// File: rtl/shift_seq_pkg.sv
// Shared types and the golden shift reference for the iterative shifter.
// The reference supports widths up to 64 bits.
package shift_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int DEF_WIDTH = 32;
  localparam int SA_W      = $clog2(DEF_WIDTH);

  function automatic logic [63:0] golden_shift(input logic [63:0] d,
                                               input int          width,
                                               input int          sa,
                                               input logic        right,
                                               input logic        arith,
                                               input logic        rotate);
    logic [63:0] r;
    logic [63:0] mask;
    logic [5:0]  top;
    logic        fill;
    logic        msb;
    logic        lsb;
    top  = 6'(width - 1);
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    r    = d & mask;
    fill = right & arith & ~rotate & r[top];
    for (int j = 0; j < 64; j++) begin
      if (j < sa) begin
        msb = r[top];
        lsb = r[0];
        if (right) begin
          r      = r >> 1;
          r[top] = rotate ? lsb : fill;
        end else begin
          r    = (r << 1) & mask;
          r[0] = rotate ? msb : 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for shift_seq; in_rotate exists only with SHIFT_SEQ_ROTATE_EN.
// master = upstream/consumer side, slave = the shift unit.
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int SAW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_d;
  logic [SAW-1:0]   in_sa;
  logic             in_right;
  logic             in_arith;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             in_rotate;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sh;
  logic             busy;

  modport master (
    output in_valid, in_d, in_sa, in_right, in_arith,
`ifdef SHIFT_SEQ_ROTATE_EN
    output in_rotate,
`endif
    output out_ready,
    input  in_ready, out_valid, out_sh, busy
  );

  modport slave (
    input  in_valid, in_d, in_sa, in_right, in_arith,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  in_rotate,
`endif
    input  out_ready,
    output in_ready, out_valid, out_sh, busy
  );

endinterface

// File: rtl/shift_step.sv
// Combinational shifter by k in 0..STEP positions; rotate input only with SHIFT_SEQ_ROTATE_EN.
// Zero latency, no flow control.
module shift_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [KW-1:0]    k_i,
  input  logic             right_i,
  input  logic             fill_i,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rotate_i,
`endif
  output logic [WIDTH-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    for (int s = 1; s <= STEP; s++) begin
      if (k_i == KW'(s)) begin
        if (right_i) begin
          word_o = (word_i >> s) | ({WIDTH{fill_i}} << (WIDTH - s));
        end else begin
          word_o = word_i << s;
        end
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rotate_i) begin
          word_o = right_i ? ((word_i >> s) | (word_i << (WIDTH - s)))
                           : ((word_i << s) | (word_i >> (WIDTH - s)));
        end
`endif
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative shifter, up to STEP bits per cycle; result valid 1+ceil(sa/STEP) cycles after accept.
// Result held until out_ready; no new request until the cycle after; SHIFT_SEQ_ROTATE_EN adds rotates.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_seq_if.slave  bus
);

  localparam int SAW = $clog2(WIDTH);
  localparam int KW  = $clog2(STEP + 1);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] step_word;
  logic [SAW-1:0]   rem_q;
  logic [SAW-1:0]   rem_d;
  logic [KW-1:0]    k_d;
  logic             right_q;
  logic             arith_q;
  logic             fill_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] orig_d_q;
  logic [SAW-1:0]   orig_sa_q;
  logic             rot_eff;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rotate_q;
  assign rot_eff = rotate_q;
`else
  assign rot_eff = 1'b0;
`endif

  always_comb begin
    if ({1'b0, rem_q} >= (SAW + 1)'(STEP)) begin
      k_d = KW'(STEP);
    end else begin
      k_d = KW'(rem_q);
    end
    rem_d = rem_q - SAW'(k_d);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .word_i   (work_q),
    .k_i      (k_d),
    .right_i  (right_q),
    .fill_i   (fill_q),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rotate_i (rotate_q),
`endif
    .word_o   (step_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      right_q     <= 1'b0;
      arith_q     <= 1'b0;
      fill_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      orig_d_q    <= '0;
      orig_sa_q   <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rotate_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.in_d;
            rem_q      <= bus.in_sa;
            right_q    <= bus.in_right;
            arith_q    <= bus.in_arith;
            fill_q     <= bus.in_right & bus.in_arith & bus.in_d[WIDTH-1];
            orig_d_q   <= bus.in_d;
            orig_sa_q  <= bus.in_sa;
`ifdef SHIFT_SEQ_ROTATE_EN
            rotate_q   <= bus.in_rotate;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.in_sa == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          work_q <= step_word;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sh    = work_q;
  assign bus.busy      = busy_q;

  // Every presented result must match the one-shot reference of the latched request.
  a_result_golden: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (work_q == WIDTH'(golden_shift(64'(orig_d_q), WIDTH, int'(orig_sa_q),
                                                         right_q, arith_q, rot_eff))));

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: driver pushes expected result and latency, negedge monitor pops and compares.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sh;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_seq_if #(.WIDTH(W)) sif();

  shift_seq #(.WIDTH(W), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  bit   head_seen = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_sel   = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first valid, data on handshake, busy while a request is in flight.
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(sif.out_valid), 32'd0);
        end else begin
          if (!head_seen) begin
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            head_seen = 1'b1;
          end
          if (sif.out_ready) begin
            check("out_sh", sif.out_sh, sb[0].sh);
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].acc) begin
        check("busy_in_flight", 32'(sif.busy), 32'd1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic [4:0] sa, input logic right,
                      input logic arith, input logic [W-1:0] exp, input int lat, input bit push);
    bit ok;
    ok = 1'b0;
    sif.in_d     = d;
    sif.in_sa    = sa;
    sif.in_right = right;
    sif.in_arith = arith;
`ifdef SHIFT_SEQ_ROTATE_EN
    sif.in_rotate = rot_sel;
`endif
    sif.in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sif.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 32'(ok), 32'd1);
    if (ok && push) sb.push_back('{exp, lat, cyc});
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_d      = '0;
    sif.in_sa     = '0;
    sif.in_right  = 1'b0;
    sif.in_arith  = 1'b0;
    sif.out_ready = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
    sif.in_rotate = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(sif.in_ready), 32'd1);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_out_sh", sif.out_sh, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 9, 1'b1);
    send(32'h8000_00F0, 5'd4,  1'b1, 1'b1, 32'hF800_000F, 2, 1'b1);
    send(32'h8000_00F0, 5'd4,  1'b1, 1'b0, 32'h0800_000F, 2, 1'b1);
    send(32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1, 1'b1);
    send(32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 9, 1'b1);
    send(32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 9, 1'b1);
    send(32'h1234_5678, 5'd8,  1'b0, 1'b0, 32'h3456_7800, 3, 1'b1);
    send(32'h1234_5678, 5'd5,  1'b1, 1'b0, 32'h0091_A2B3, 3, 1'b1);
    send(32'h7000_0000, 5'd3,  1'b1, 1'b1, 32'h0E00_0000, 2, 1'b1);
    send(32'h1234_5678, 5'd1,  1'b0, 1'b1, 32'h2468_ACF0, 2, 1'b1);
    drain();

    // Backpressure: result must sit still for five cycles and ignore a new request.
    sif.out_ready = 1'b0;
    send(32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_0F00, 2, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sif.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_reach_done", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      sif.in_valid = (i == 2);
      sif.in_d     = 32'hFFFF_0000;
      sif.in_sa    = 5'd3;
      @(negedge clk);
      check("bp_out_valid", 32'(sif.out_valid), 32'd1);
      check("bp_out_sh", sif.out_sh, 32'h0000_0F00);
      check("bp_in_ready", 32'(sif.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    send(32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 2, 1'b1);
    drain();

    // Reset on the second BUSY cycle, asserted together with a competing request.
    send(32'h0000_0001, 5'd20, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_d     = 32'h0000_0005;
    sif.in_sa    = 5'd3;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    sif.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(sif.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    @(posedge clk);
    #1;
    send(32'h0000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0002, 2, 1'b1);

`ifdef SHIFT_SEQ_ROTATE_EN
    rot_sel = 1'b1;
    send(32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'hC000_0000, 2, 1'b1);
    send(32'h8000_0001, 5'd4, 1'b0, 1'b0, 32'h0000_0018, 2, 1'b1);
    send(32'h1234_5678, 5'd8, 1'b1, 1'b0, 32'h7812_3456, 3, 1'b1);
    rot_sel = 1'b0;
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
